// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 raster timing. Free-running pixel/line counters,
//               undelayed visible flag for the sprite mappers, sync/blank
//               delayed to line up with mapper RGB, and a per-frame tick at
//               the start of vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_out,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] C_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] C_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Counters are 10 bits wide; larger rasters cannot be represented.
  generate
    if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_DELAY must be 0..4");
    end
  endgenerate

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       frame_tick_q, frame_tick_d;
  logic       hs_raw, vs_raw, blank_raw;

  // Next-position logic: pixel counter wraps each line, line counter each frame.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == C_H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == C_V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
  end

  // Raster position and frame tick registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q         <= '0;
      vc_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Tick fires one cycle after the first pixel slot of vertical blanking.
  assign frame_tick_d = (hc_q == 10'd0) && (vc_q == C_V_VIS);

  // Raw decodes straight from the counters; syncs are active-low.
  assign hs_raw    = !((hc_q >= C_HS_START) && (hc_q < C_HS_END));
  assign vs_raw    = !((vc_q >= C_VS_START) && (vc_q < C_VS_END));
  assign blank_raw = (hc_q < C_H_VIS) && (vc_q < C_V_VIS);

  assign DrawX      = hc_q;
  assign DrawY      = vc_q;
  assign blank      = blank_raw;
  assign frame_tick = frame_tick_q;

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign hs        = hs_raw;
      assign vs        = vs_raw;
      assign blank_out = blank_raw;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] hs_q, vs_q, blank_q;

      // Shift registers matching mapper latency; reset to inactive sync / blanked.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_q    <= '1;
          vs_q    <= '1;
          blank_q <= '0;
        end else begin
          hs_q    <= (hs_q << 1)    | PIPE_DELAY'(hs_raw);
          vs_q    <= (vs_q << 1)    | PIPE_DELAY'(vs_raw);
          blank_q <= (blank_q << 1) | PIPE_DELAY'(blank_raw);
        end
      end

      assign hs        = hs_q[PIPE_DELAY-1];
      assign vs        = vs_q[PIPE_DELAY-1];
      assign blank_out = blank_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule
`default_nettype wire
